// File: rtl/cc_psr.sv
// -----------------------------------------------------------------------------
// cc_psr -- processor status register for the micro-datapath.
//
// Sits directly downstream of the ALU. It holds the N/Z/V/C condition flags,
// keeps a one-deep shadow copy for trap/interrupt save and restore, and
// evaluates a 4-bit SPARC Bicc-style branch condition against the flags. The
// taken/not-taken result goes back to the microsequencer one cycle later.
//
// Ports
//   CC_PSR_CLOCK_50          in   system clock, rising-edge active
//   CC_PSR_RESET_InLow       in   asynchronous active-low reset
//   CC_PSR_negative_InLow    in   ALU N flag (active-low)
//   CC_PSR_zero_InLow        in   ALU Z flag (active-low)
//   CC_PSR_overflow_InLow    in   ALU V flag (active-low)
//   CC_PSR_carry_InLow       in   ALU C flag (active-low)
//   CC_PSR_SetCode_In        in   capture the ALU flags at this edge
//   CC_PSR_save_In           in   copy the current flags into the shadow
//   CC_PSR_restore_In        in   load the flags from the shadow
//   CC_PSR_evaluate_In       in   request a condition evaluation
//   CC_PSR_condition_InBus   in   condition select, sampled with evaluate
//   CC_PSR_flags_OutBus      out  stored flags, active-high, {N,Z,V,C}
//   CC_PSR_condTrue_Out      out  registered evaluation result (held)
//   CC_PSR_condValid_Out     out  one-cycle pulse, condTrue valid this cycle
//   CC_PSR_shadowValid_Out   out  shadow holds a saved flag set
//   CC_PSR_restoreErr_Out    out  one-cycle pulse, restore with empty shadow
//
// All outputs come straight from flops; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module cc_psr #(
  parameter int DATAWIDTH_FLAGS = 4,
  parameter int DATAWIDTH_COND  = 4
) (
  input  logic                       CC_PSR_CLOCK_50,
  input  logic                       CC_PSR_RESET_InLow,
  input  logic                       CC_PSR_negative_InLow,
  input  logic                       CC_PSR_zero_InLow,
  input  logic                       CC_PSR_overflow_InLow,
  input  logic                       CC_PSR_carry_InLow,
  input  logic                       CC_PSR_SetCode_In,
  input  logic                       CC_PSR_save_In,
  input  logic                       CC_PSR_restore_In,
  input  logic                       CC_PSR_evaluate_In,
  input  logic [DATAWIDTH_COND-1:0]  CC_PSR_condition_InBus,
  output logic [DATAWIDTH_FLAGS-1:0] CC_PSR_flags_OutBus,
  output logic                       CC_PSR_condTrue_Out,
  output logic                       CC_PSR_condValid_Out,
  output logic                       CC_PSR_shadowValid_Out,
  output logic                       CC_PSR_restoreErr_Out
);

  // Bit positions inside the {N,Z,V,C} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // ---------------------------------------------------------------------------
  // Flag capture: the ALU drives its flags active-low; store them active-high.
  // ---------------------------------------------------------------------------
  logic [DATAWIDTH_FLAGS-1:0] aluFlagsLow;
  logic [DATAWIDTH_FLAGS-1:0] captureFlags;

  assign aluFlagsLow = {CC_PSR_negative_InLow, CC_PSR_zero_InLow,
                        CC_PSR_overflow_InLow, CC_PSR_carry_InLow};

  generate
    for (genvar gi = 0; gi < DATAWIDTH_FLAGS; gi++) begin : g_capture
      assign captureFlags[gi] = ~aluFlagsLow[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATAWIDTH_FLAGS-1:0] flagsReg;
  logic [DATAWIDTH_FLAGS-1:0] flagsNext;
  logic [DATAWIDTH_FLAGS-1:0] shadowReg;
  logic [DATAWIDTH_FLAGS-1:0] shadowNext;
  logic                       shadowValidReg;
  logic                       shadowValidNext;
  logic                       condTrueReg;
  logic                       condTrueNext;
  logic                       condValidReg;
  logic                       restoreErrReg;
  logic                       restoreErrNext;

  // A restore only takes effect when the shadow actually holds something.
  logic restoreOk;
  assign restoreOk = CC_PSR_restore_In & shadowValidReg;

  // ---------------------------------------------------------------------------
  // Flag and shadow next-state.
  // Restore beats SetCode. Save always captures the pre-update flags, so a
  // save+restore in one cycle with a valid shadow exchanges the two copies.
  // ---------------------------------------------------------------------------
  always_comb begin
    flagsNext       = flagsReg;
    shadowNext      = shadowReg;
    shadowValidNext = shadowValidReg;
    restoreErrNext  = CC_PSR_restore_In & ~shadowValidReg;

    if (restoreOk) begin
      flagsNext = shadowReg;
    end else if (CC_PSR_SetCode_In) begin
      flagsNext = captureFlags;
    end

    if (CC_PSR_save_In) begin
      shadowNext      = flagsReg;
      shadowValidNext = 1'b1;
    end else if (restoreOk) begin
      shadowValidNext = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Condition evaluation on the forwarded flags (flagsNext), so a same-cycle
  // SetCode or restore is already visible to the branch decision.
  // The low three select bits pick the base test; the top bit inverts it.
  // ---------------------------------------------------------------------------
  logic condBase;
  logic condResult;
  logic fN, fZ, fV, fC;

  assign fN = flagsNext[FLAG_N];
  assign fZ = flagsNext[FLAG_Z];
  assign fV = flagsNext[FLAG_V];
  assign fC = flagsNext[FLAG_C];

  always_comb begin
    condBase = 1'b0;
    unique case (CC_PSR_condition_InBus[2:0])
      3'd0: condBase = 1'b0;              // never / always
      3'd1: condBase = fZ;                // E   / NE
      3'd2: condBase = fZ | (fN ^ fV);    // LE  / G
      3'd3: condBase = fN ^ fV;           // L   / GE
      3'd4: condBase = fC | fZ;           // LEU / GU
      3'd5: condBase = fC;                // CS  / CC
      3'd6: condBase = fN;                // NEG / POS
      3'd7: condBase = fV;                // VS  / VC
      default: condBase = 1'b0;
    endcase
  end

  assign condResult = condBase ^ CC_PSR_condition_InBus[DATAWIDTH_COND-1];

  // condTrue holds its last value between evaluations.
  always_comb begin
    condTrueNext = condTrueReg;
    if (CC_PSR_evaluate_In) begin
      condTrueNext = condResult;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset clears everything immediately, including an evaluation
  // that was already in flight, so no stale condValid pulse can escape.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
    if (!CC_PSR_RESET_InLow) begin
      flagsReg       <= '0;
      shadowReg      <= '0;
      shadowValidReg <= 1'b0;
      condTrueReg    <= 1'b0;
      condValidReg   <= 1'b0;
      restoreErrReg  <= 1'b0;
    end else begin
      flagsReg       <= flagsNext;
      shadowReg      <= shadowNext;
      shadowValidReg <= shadowValidNext;
      condTrueReg    <= condTrueNext;
      condValidReg   <= CC_PSR_evaluate_In;
      restoreErrReg  <= restoreErrNext;
    end
  end

  assign CC_PSR_flags_OutBus    = flagsReg;
  assign CC_PSR_condTrue_Out    = condTrueReg;
  assign CC_PSR_condValid_Out   = condValidReg;
  assign CC_PSR_shadowValid_Out = shadowValidReg;
  assign CC_PSR_restoreErr_Out  = restoreErrReg;

endmodule

// File: tb/tb_cc_psr.sv
// -----------------------------------------------------------------------------
// tb_cc_psr -- self-checking bench for cc_psr.
// A behavioural model tracks flags/shadow/result from the documented rules;
// one compare process checks every DUT output against it on each falling
// edge. Directed steps additionally check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_cc_psr;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       nLow = 1'b1, zLow = 1'b1, vLow = 1'b1, cLow = 1'b1;
  logic       setCode = 1'b0, save = 1'b0, restore = 1'b0, evaluate = 1'b0;
  logic [3:0] condSel = 4'd0;
  logic [3:0] flagsOut;
  logic       condTrue, condValid, shadowValid, restoreErr;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  cc_psr #(.DATAWIDTH_FLAGS(4), .DATAWIDTH_COND(4)) dut (
    .CC_PSR_CLOCK_50        (clk),
    .CC_PSR_RESET_InLow     (rstN),
    .CC_PSR_negative_InLow  (nLow),
    .CC_PSR_zero_InLow      (zLow),
    .CC_PSR_overflow_InLow  (vLow),
    .CC_PSR_carry_InLow     (cLow),
    .CC_PSR_SetCode_In      (setCode),
    .CC_PSR_save_In         (save),
    .CC_PSR_restore_In      (restore),
    .CC_PSR_evaluate_In     (evaluate),
    .CC_PSR_condition_InBus (condSel),
    .CC_PSR_flags_OutBus    (flagsOut),
    .CC_PSR_condTrue_Out    (condTrue),
    .CC_PSR_condValid_Out   (condValid),
    .CC_PSR_shadowValid_Out (shadowValid),
    .CC_PSR_restoreErr_Out  (restoreErr)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [3:0] mFlags = 4'd0, mShadow = 4'd0;
  logic       mSv = 1'b0, mTrue = 1'b0, mValid = 1'b0, mErr = 1'b0;

  // Branch truth from named flags; codes 8..15 are the negations of 0..7.
  function automatic logic branchTaken(input logic [3:0] f, input logic [3:0] sel);
    logic n, z, v, c, t;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (sel & 4'h7)
      4'h0: t = 1'b0;
      4'h1: t = z;
      4'h2: t = z || (n != v);
      4'h3: t = (n != v);
      4'h4: t = c || z;
      4'h5: t = c;
      4'h6: t = n;
      default: t = v;
    endcase
    return (sel >= 4'h8) ? !t : t;
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mFlags <= 4'd0; mShadow <= 4'd0; mSv <= 1'b0;
      mTrue <= 1'b0; mValid <= 1'b0; mErr <= 1'b0;
    end else begin
      logic [3:0] nf;
      if (restore && mSv)  nf = mShadow;
      else if (setCode)    nf = {!nLow, !zLow, !vLow, !cLow};
      else                 nf = mFlags;
      mFlags <= nf;
      if (save) begin
        mShadow <= mFlags;
        mSv     <= 1'b1;
      end else if (restore && mSv) begin
        mSv <= 1'b0;
      end
      mErr   <= restore && !mSv;
      mValid <= evaluate;
      if (evaluate) mTrue <= branchTaken(nf, condSel);
    end
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b at %0t", name, got, want, $time);
    end
  endtask

  // Single compare process against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      check("model.flags",       flagsOut,           mFlags);
      check("model.condValid",   {3'b0, condValid},  {3'b0, mValid});
      check("model.condTrue",    {3'b0, condTrue},   {3'b0, mTrue});
      check("model.shadowValid", {3'b0, shadowValid},{3'b0, mSv});
      check("model.restoreErr",  {3'b0, restoreErr}, {3'b0, mErr});
    end
  end

  // One transaction: drive after a falling edge, let one rising edge pass,
  // then return to idle 1 time unit later.
  task automatic apply(input logic [3:0] low, input logic sc, input logic sv,
                       input logic rs, input logic ev, input logic [3:0] cs);
    @(negedge clk);
    {nLow, zLow, vLow, cLow} = low;
    setCode = sc; save = sv; restore = rs; evaluate = ev; condSel = cs;
    @(posedge clk);
    #1;
    {nLow, zLow, vLow, cLow} = 4'b1111;
    setCode = 0; save = 0; restore = 0; evaluate = 0; condSel = 4'd0;
    $display("txn low=%b set=%b save=%b rest=%b eval=%b cond=%b -> flags=%b true=%b valid=%b sv=%b err=%b",
             low, sc, sv, rs, ev, cs, flagsOut, condTrue, condValid, shadowValid, restoreErr);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".flags"}, flagsOut, 4'b0000);
    check({tag, ".out"}, {condTrue, condValid, shadowValid, restoreErr}, 4'b0000);
  endtask

  initial begin
    #1 rstN = 1'b0;
    checkEn = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkAllZero("reset");
    @(negedge clk); #1 rstN = 1'b1;

    // Capture and hold.
    apply(4'b1011, 1, 0, 0, 0, 4'h0);
    check("capture.z", flagsOut, 4'b0100);
    apply(4'b0000, 0, 0, 0, 0, 4'h0);
    check("hold.noset", flagsOut, 4'b0100);

    // Forwarded evaluate.
    apply(4'b0000, 1, 0, 0, 1, 4'b0101);
    check("fwd.cs.valid", {3'b0, condValid}, 4'd1);
    check("fwd.cs.true", {3'b0, condTrue}, 4'd1);
    check("fwd.flags", flagsOut, 4'b1111);
    apply(4'b0000, 1, 0, 0, 1, 4'b1101);
    check("fwd.cc.true", {3'b0, condTrue}, 4'd0);

    // Signed compare with N=1, V=0.
    apply(4'b0111, 1, 0, 0, 1, 4'b0011);
    check("signed.L", {3'b0, condTrue}, 4'd1);
    apply(4'b1111, 0, 0, 0, 1, 4'b1011);
    check("signed.GE", {3'b0, condTrue}, 4'd0);
    apply(4'b1111, 0, 0, 0, 1, 4'b1010);
    check("signed.G", {3'b0, condTrue}, 4'd0);
    apply(4'b1111, 0, 0, 0, 0, 4'h0);
    check("idle.noValid", {3'b0, condValid}, 4'd0);

    // Back-to-back evaluates: always, then never.
    apply(4'b1111, 0, 0, 0, 1, 4'b1000);
    check("b2b.A", {3'b0, condTrue}, 4'd1);
    apply(4'b1111, 0, 0, 0, 1, 4'b0000);
    check("b2b.N.valid", {3'b0, condValid}, 4'd1);
    check("b2b.N.true", {3'b0, condTrue}, 4'd0);

    // Save / restore.
    apply(4'b0110, 1, 0, 0, 0, 4'h0);
    check("sr.flags1001", flagsOut, 4'b1001);
    apply(4'b1111, 0, 1, 0, 0, 4'h0);
    check("sr.saved", {3'b0, shadowValid}, 4'd1);
    apply(4'b1101, 1, 0, 0, 0, 4'h0);
    check("sr.flags0010", flagsOut, 4'b0010);
    apply(4'b1111, 0, 0, 1, 0, 4'h0);
    check("sr.restored", flagsOut, 4'b1001);
    check("sr.svCleared", {3'b0, shadowValid}, 4'd0);
    apply(4'b1111, 0, 0, 1, 0, 4'h0);
    check("sr.err", {3'b0, restoreErr}, 4'd1);
    check("sr.errFlags", flagsOut, 4'b1001);
    apply(4'b1111, 0, 0, 0, 0, 4'h0);
    check("sr.errPulse", {3'b0, restoreErr}, 4'd0);

    // Save+restore with empty shadow: save happens, error pulses, SetCode wins.
    apply(4'b1110, 1, 1, 1, 0, 4'h0);
    check("emptySwap.flags", flagsOut, 4'b0001);
    check("emptySwap.err", {3'b0, restoreErr}, 4'd1);
    check("emptySwap.sv", {3'b0, shadowValid}, 4'd1);
    // shadow now holds 1001; overwrite it with 0001 (save without error).
    apply(4'b1111, 0, 1, 0, 0, 4'h0);
    check("overwrite.err", {3'b0, restoreErr}, 4'd0);
    apply(4'b0011, 1, 0, 0, 0, 4'h0);
    check("swap.pre", flagsOut, 4'b1100);
    // Swap with SetCode(0110) also asserted: restore wins.
    apply(4'b1001, 1, 1, 1, 0, 4'h0);
    check("swap.flags", flagsOut, 4'b0001);
    check("swap.sv", {3'b0, shadowValid}, 4'd1);
    apply(4'b1111, 0, 0, 1, 0, 4'h0);
    check("swap.shadow", flagsOut, 4'b1100);

    // Async reset while an evaluation result is pending.
    apply(4'b1111, 0, 1, 0, 0, 4'h0);
    @(negedge clk);
    evaluate = 1'b1; condSel = 4'b1000;
    @(posedge clk);
    #1 evaluate = 1'b0; condSel = 4'd0;
    #2 rstN = 1'b0;
    #1 checkAllZero("asyncReset");
    @(negedge clk); #1 rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("postReset.noPulse", {3'b0, condValid}, 4'd0);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
